// File: rtl/ones_pattern_gen.sv
// Streams every IN_LEN-bit word with exactly k ones, in ascending order, using a
// valid/ready handshake. A Gosper successor is used to step from word to word.
module ones_pattern_gen #(
    parameter int IN_LEN  = 32,
    parameter int OUT_LEN = 6    // 2**OUT_LEN must exceed IN_LEN so in_k can express IN_LEN
) (
    input  logic               sys_clk,
    input  logic               in_rst_n,
    input  logic               in_start,
    input  logic [OUT_LEN-1:0] in_k,
    input  logic               in_ready,
    output logic [IN_LEN-1:0]  out_dat,
    output logic               out_valid,
    output logic               out_last,
    output logic               out_busy,
    output logic               out_err
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [IN_LEN-1:0]  ONES  = '1;
    localparam logic [OUT_LEN:0]   LEN_C = (OUT_LEN+1)'(IN_LEN);

    state_e              state_q;
    logic [OUT_LEN-1:0]  k_q;
    logic [IN_LEN-1:0]   dat_q;
    logic                valid_q;
    logic                last_q;
    logic                err_q;

    logic [IN_LEN-1:0]   low_c, ripple_r, dat_succ_d, dat_ld_d;
    logic [OUT_LEN-1:0]  ctz;
    logic                last_succ_d, last_ld_d, k_ok;

    // k ones packed at the bottom; a shift by IN_LEN yields the all-ones word.
    function automatic logic [IN_LEN-1:0] lsb_ones(input logic [OUT_LEN-1:0] k);
        return ~(ONES << k);
    endfunction

    // k ones packed at the top: the final word of a sequence.
    function automatic logic [IN_LEN-1:0] msb_ones(input logic [OUT_LEN-1:0] k);
        return ~(ONES >> k);
    endfunction

    always_comb begin
        low_c    = dat_q & (~dat_q + IN_LEN'(1));
        ripple_r = dat_q + low_c;
        ctz      = '0;
        for (int i = 0; i < IN_LEN; i++) begin
            if (low_c[i]) ctz = OUT_LEN'(i);
        end
        dat_succ_d  = (((ripple_r ^ dat_q) >> 2) >> ctz) | ripple_r;
        last_succ_d = (dat_succ_d == msb_ones(k_q));
        dat_ld_d    = lsb_ones(in_k);
        last_ld_d   = (dat_ld_d == msb_ones(in_k));
        k_ok        = ({1'b0, in_k} <= LEN_C);
    end

    always_ff @(posedge sys_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_start) begin
                        if (k_ok) begin
                            k_q     <= in_k;
                            dat_q   <= dat_ld_d;
                            last_q  <= last_ld_d;
                            valid_q <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The successor of the final word is never loaded, so no wrap.
                    if (valid_q && in_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            dat_q  <= dat_succ_d;
                            last_q <= last_succ_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_dat   = dat_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_busy  = (state_q == RUN);
    assign out_err   = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: a 32-bit and an 8-bit instance, each checked against
// a scoreboard of expected words built by the bench when a start is issued.
module tb_ones_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s32, r32, v32, l32, b32, e32;
    logic [5:0]  k32;
    logic [31:0] d32;
    logic        s8, r8, v8, l8, b8, e8;
    logic [3:0]  k8;
    logic [7:0]  d8;

    ones_pattern_gen #(.IN_LEN(32), .OUT_LEN(6)) u32 (
        .sys_clk(clk), .in_rst_n(rst_n), .in_start(s32), .in_k(k32), .in_ready(r32),
        .out_dat(d32), .out_valid(v32), .out_last(l32), .out_busy(b32), .out_err(e32));

    ones_pattern_gen #(.IN_LEN(8), .OUT_LEN(4)) u8 (
        .sys_clk(clk), .in_rst_n(rst_n), .in_start(s8), .in_k(k8), .in_ready(r8),
        .out_dat(d8), .out_valid(v8), .out_last(l8), .out_busy(b8), .out_err(e8));

    typedef struct { logic [31:0] dat; logic last; } exp_t;
    exp_t q32[$];
    exp_t q8[$];

    int errors = 0;
    int checks = 0;
    int xfer32 = 0, xfer8 = 0, cur_k8 = 0;
    logic [31:0] log32 [0:7];
    logic [31:0] lastw32;
    logic        pv32 = 0, pr32 = 0, pl32 = 0, pv8 = 0, pr8 = 0, pl8 = 0;
    logic [31:0] pd32 = 0;
    logic [7:0]  pd8 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next word with the same popcount: move the lowest "01" bit up, pack lower ones down.
    function automatic logic [31:0] nxt32(input logic [31:0] x);
        logic [31:0] y;
        int cnt = 0;
        int p = -1;
        for (int i = 0; i < 31; i++) begin
            if (p < 0) begin
                if (x[i] && !x[i+1]) p = i;
                else if (x[i]) cnt++;
            end
        end
        y = x;
        for (int i = 0; i <= p; i++) y[i] = 1'b0;
        y[p+1] = 1'b1;
        for (int i = 0; i < cnt; i++) y[i] = 1'b1;
        return y;
    endfunction

    task automatic push32(input int k);
        logic [31:0] m = '0;
        logic [31:0] x = '0;
        exp_t e;
        for (int i = 0; i < k; i++) begin m[31-i] = 1'b1; x[i] = 1'b1; end
        for (int n = 0; n < 100000; n++) begin
            e.dat = x; e.last = (x == m);
            q32.push_back(e);
            if (x == m) break;
            x = nxt32(x);
        end
    endtask

    task automatic push8(input int k);
        int total = 0, idx = 0;
        exp_t e;
        for (int v = 0; v < 256; v++) if ($countones(8'(v)) == k) total++;
        for (int v = 0; v < 256; v++) begin
            if ($countones(8'(v)) == k) begin
                e.dat = 32'(v); e.last = (idx == total - 1);
                q8.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic mon32();
        exp_t e;
        if (!rst_n) begin pv32 = 0; return; end
        if (pv32 && !pr32) begin
            chk("hold32_dat", 64'(d32), 64'(pd32));
            chk("hold32_last", 64'(l32), 64'(pl32));
        end
        if (v32 && r32) begin
            if (q32.size() == 0) chk("extra32", 64'(v32), 64'(0));
            else begin
                e = q32.pop_front();
                chk("dat32", 64'(d32), 64'(e.dat));
                chk("last32", 64'(l32), 64'(e.last));
            end
            if (xfer32 < 8) log32[xfer32] = d32;
            if (l32) lastw32 = d32;
            xfer32++;
        end
        pv32 = v32; pr32 = r32; pd32 = d32; pl32 = l32;
    endtask

    task automatic mon8();
        exp_t e;
        if (!rst_n) begin pv8 = 0; return; end
        if (pv8 && !pr8) begin
            chk("hold8_dat", 64'(d8), 64'(pd8));
            chk("hold8_last", 64'(l8), 64'(pl8));
        end
        if (v8 && r8) begin
            chk("pop8", 64'($countones(d8)), 64'(cur_k8));
            if (q8.size() == 0) chk("extra8", 64'(v8), 64'(0));
            else begin
                e = q8.pop_front();
                chk("dat8", 64'(d8), 64'(e.dat));
                chk("last8", 64'(l8), 64'(e.last));
            end
            xfer8++;
        end
        pv8 = v8; pr8 = r8; pd8 = d8; pl8 = l8;
    endtask

    initial forever begin @(negedge clk); mon32(); mon8(); end

    task automatic start32(input int k);
        push32(k);
        @(posedge clk); #1 r32 = 1'b1; s32 = 1'b1; k32 = 6'(k);
        @(posedge clk); #1 s32 = 1'b0;
    endtask

    task automatic start8(input int k);
        cur_k8 = k;
        push8(k);
        @(posedge clk); #1 r8 = 1'b1; s8 = 1'b1; k8 = 4'(k);
        @(posedge clk); #1 s8 = 1'b0;
    endtask

    task automatic run32(input string tag, input int exp_n, input bit rnd, output int cyc);
        bit done = 0;
        cyc = 0;
        for (int n = 0; n < 20000 && !done; n++) begin
            @(posedge clk); #1 r32 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1 cyc++;
            if (!v32 && q32.size() == 0) done = 1;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_cnt"}, 64'(xfer32), 64'(exp_n));
        xfer32 = 0; r32 = 1'b1;
    endtask

    task automatic run8(input string tag, input int exp_n);
        bit done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(posedge clk); #1 r8 = 1'($urandom_range(0, 1));
            #1 if (!v8 && q8.size() == 0) done = 1;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_cnt"}, 64'(xfer8), 64'(exp_n));
        xfer8 = 0; r8 = 1'b1;
    endtask

    int cyc;
    int cnt8 [0:8] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};

    initial begin
        rst_n = 1'b0; s32 = 0; k32 = '0; r32 = 1'b1; s8 = 0; k8 = '0; r8 = 1'b1;
        #2;
        chk("rst_dat", 64'(d32), 64'(0));
        chk("rst_valid", 64'(v32), 64'(0));
        chk("rst_last", 64'(l32), 64'(0));
        chk("rst_busy", 64'(b32), 64'(0));
        chk("rst_err", 64'(e32), 64'(0));
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        for (int k = 0; k <= 8; k++) begin
            start8(k);
            run8($sformatf("k8_%0d", k), cnt8[k]);
        end

        start32(1);
        run32("k1", 32, 0, cyc);
        chk("k1_cycles", 64'(cyc), 64'(32));
        chk("k1_w0", 64'(log32[0]), 64'h1);
        chk("k1_w2", 64'(log32[2]), 64'h4);
        chk("k1_lastw", 64'(lastw32), 64'h8000_0000);

        start32(2);
        run32("k2", 496, 0, cyc);
        chk("k2_w0", 64'(log32[0]), 64'h3);
        chk("k2_w1", 64'(log32[1]), 64'h5);
        chk("k2_w2", 64'(log32[2]), 64'h6);
        chk("k2_w3", 64'(log32[3]), 64'h9);
        chk("k2_w4", 64'(log32[4]), 64'hA);
        chk("k2_w5", 64'(log32[5]), 64'hC);
        chk("k2_w6", 64'(log32[6]), 64'h11);

        start32(31);
        run32("k31", 32, 1, cyc);
        chk("k31_w0", 64'(log32[0]), 64'h7FFF_FFFF);
        chk("k31_w1", 64'(log32[1]), 64'hBFFF_FFFF);
        chk("k31_lastw", 64'(lastw32), 64'hFFFF_FFFE);

        start32(0);
        run32("k0", 1, 0, cyc);
        chk("k0_w0", 64'(log32[0]), 64'h0);
        start32(32);
        run32("k32", 1, 0, cyc);
        chk("k32_w0", 64'(log32[0]), 64'hFFFF_FFFF);

        // Out-of-range k: one-cycle error pulse, nothing else moves.
        @(posedge clk); #1 s32 = 1'b1; k32 = 6'd33;
        @(posedge clk); #1 s32 = 1'b0;
        chk("err_pulse", 64'(e32), 64'(1));
        chk("err_valid", 64'(v32), 64'(0));
        chk("err_busy", 64'(b32), 64'(0));
        chk("err_dat", 64'(d32), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("err_clear", 64'(e32), 64'(0));
        chk("err_valid2", 64'(v32), 64'(0));

        // A start during RUN must be ignored.
        start32(3);
        chk("k3_busy", 64'(b32), 64'(1));
        repeat (5) @(posedge clk);
        #1 s32 = 1'b1; k32 = 6'd5;
        @(posedge clk); #1 s32 = 1'b0;
        run32("k3", 4960, 1, cyc);

        // Reset mid-sequence, no resume, then a fresh start.
        start32(3);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_dat", 64'(d32), 64'(0));
        chk("mid_rst_valid", 64'(v32), 64'(0));
        chk("mid_rst_last", 64'(l32), 64'(0));
        chk("mid_rst_busy", 64'(b32), 64'(0));
        q32.delete(); xfer32 = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_resume_valid", 64'(v32), 64'(0));
        chk("no_resume_busy", 64'(b32), 64'(0));
        start32(4);
        chk("k4_first", 64'(d32), 64'hF);
        chk("k4_valid", 64'(v32), 64'(1));
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        q32.delete(); xfer32 = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 The block SHALL take parameter IN_LEN, default 32, giving the output word width in bits.
REQ-002 The block SHALL take parameter OUT_LEN, default 6, giving the ones-count width; the block SHALL require 2^OUT_LEN > IN_LEN.
REQ-003 sys_clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-004 in_rst_n  input  1  The reset SHALL be asynchronous and active-low.
REQ-005 in_start  input  1  The start request, sampled only in IDLE.
REQ-006 in_k  input  OUT_LEN  The requested number of ones per word, sampled with in_start.
REQ-007 in_ready  input  1  The downstream accept; a transfer SHALL occur when out_valid and in_ready are both high.
REQ-008 out_dat  output  IN_LEN  The current word; it SHALL contain exactly k ones.
REQ-009 out_valid  output  1  out_dat holds a word not yet transferred.
REQ-010 out_last  output  1  The current word is the final word of the sequence; it SHALL be meaningful only while out_valid is high.
REQ-011 out_busy  output  1  The FSM is in RUN.
REQ-012 out_err  output  1  A one-cycle pulse signalling that a start request had in_k > IN_LEN.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-014 In IDLE, if in_start=1 and in_k<=IN_LEN, the block SHALL latch k=in_k, load out_dat=(1<<k)-1 (the k LSBs set), set out_valid=1, and enter RUN; the first word SHALL be valid in the cycle after in_start.
REQ-015 In IDLE, if in_start=1 and in_k>IN_LEN, the block SHALL pulse out_err for exactly one cycle, leave out_dat unchanged, and remain in IDLE.
REQ-016 In RUN, the block SHALL ignore in_start and in_k; the latched k SHALL NOT change until the next start.
REQ-017 While out_valid=1 and in_ready=0, out_dat and out_last SHALL be held stable.
REQ-018 On a transfer of a non-last word, the next out_dat SHALL be the next larger unsigned IN_LEN-bit value with exactly k ones (Gosper successor: c=x&-x; r=x+c; next=(((r^x)>>2)>>ctz(c))|r), presented in the following cycle with out_valid still high, sustaining one word per cycle under continuous in_ready.
REQ-019 out_last SHALL be 1 exactly when out_dat equals the k ones placed in the MSBs (the value 0 when k=0, all ones when k=IN_LEN).
REQ-020 On a transfer with out_last=1, the block SHALL clear out_valid and return to IDLE in the next cycle; a new in_start SHALL be accepted from that IDLE cycle onward.
REQ-021 The successor arithmetic SHALL NOT wrap: the successor of the last word SHALL never be loaded, so every transferred sequence is strictly ascending and contains exactly C(IN_LEN,k) words.
REQ-022 For k=0 and for k=IN_LEN, exactly one word (0, or all ones respectively) SHALL be emitted, with out_last=1.
REQ-023 out_busy SHALL be 1 exactly while the FSM is in RUN.

Reset
REQ-024 Asserting in_rst_n=0 at any time, including mid-sequence with out_valid high, SHALL immediately force IDLE, out_dat=0, out_valid=0, out_last=0, out_busy=0, out_err=0, and latched k=0.
REQ-025 After in_rst_n deasserts, the block SHALL remain in IDLE until in_start is sampled high; an interrupted sequence SHALL NOT resume.

Verification
REQ-026 IN_LEN=32, k=1, in_ready=1 -> 32 words 0x1,0x2,0x4,...,0x80000000 on consecutive cycles; out_last=1 only on 0x80000000; out_valid=0 in the following cycle.
REQ-027 IN_LEN=32, k=2 -> first words 0x3,0x5,0x6,0x9,0xA,0xC,0x11; k=31 -> 0x7FFFFFFF,0xBFFFFFFF,...,0xFFFFFFFE, 32 words in total.
REQ-028 IN_LEN=8, each k=0..8 with random in_ready -> every word checked against a count_1 instance (out_1_cnt==k) and against a strictly ascending order; word counts 1,8,28,56,70,56,28,8,1; no word lost or duplicated under stalls.
REQ-029 k=0 -> a single word 0x00000000 with out_last=1; k=32 -> a single word 0xFFFFFFFF with out_last=1; k=33 -> out_err pulses for one cycle, out_valid stays 0, out_busy stays 0.
REQ-030 in_start with k=5 pulsed during RUN (k=3) -> ignored, and the k=3 sequence completes unchanged; in_rst_n pulsed low mid-sequence -> all outputs 0 at once, then a fresh start with k=4 begins at 0x0000000F.
